// File: rtl/fp_conv_pkg.sv
// Shared constants, state encoding and result type for the 12-bit two's-complement
// to 8-bit floating-point converter (sign, 3-bit exponent, 4-bit significand).
package fp_conv_pkg;

  localparam int DW = 12;
  localparam int EW = 3;
  localparam int FW = 4;
  localparam int MW = DW - 1;

  localparam logic [EW-1:0] EXP_MAX   = 3'd7;
  localparam logic [FW-1:0] F_SAT     = 4'hF;
  localparam logic [FW-1:0] F_CARRY   = 4'b1000;
  localparam logic [MW-1:0] MAG_CLAMP = 11'd2047;
  localparam logic [DW-1:0] TC_MIN    = 12'h800;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic          s;
    logic [EW-1:0] e;
    logic [FW-1:0] f;
  } fp8_t;

  // Normalization stops once the leading one reaches the top or the exponent runs out.
  function automatic logic norm_done(input logic [MW-1:0] m, input logic [EW-1:0] e);
    return m[MW-1] || (e == '0);
  endfunction

endpackage

// File: rtl/fp_conv_ctrl_tc_to_sm.sv
// Combinational two's-complement to sign/magnitude split.
// The magnitude keeps the full input width so the most-negative value stays representable.
module tc_to_sm #(
  parameter int DW = 12
) (
  input  logic [DW-1:0] tc_i,
  output logic          sign_o,
  output logic [DW-1:0] mag_o
);

  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  assign sign_o = tc_i[DW-1];
  assign mag_o  = tc_i[DW-1] ? (~tc_i + ONE) : tc_i;

endmodule

// File: rtl/fp_conv_ctrl.sv
// Sequencer: accepts a 12-bit sample, normalizes one bit per cycle, then rounds.
// Build option FP_ROUND_EN selects round-to-nearest; otherwise the significand truncates.
module fp_conv_ctrl
  import fp_conv_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_s,
  output logic [EW-1:0] out_e,
  output logic [FW-1:0] out_f,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [MW-1:0] m_q, m_d;
  logic [EW-1:0] exp_q, exp_d;
  logic          sign_q, sign_d;
  fp8_t          res_q, res_d;

  logic          sm_sign;
  logic [DW-1:0] sm_mag;
  logic          clamp;

  tc_to_sm #(.DW(DW)) u_tc_to_sm (
    .tc_i   (in_d),
    .sign_o (sm_sign),
    .mag_o  (sm_mag)
  );

  // Either flag marks the single input whose magnitude does not fit in MW bits.
  assign clamp = (in_d == TC_MIN) || sm_mag[DW-1];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
    end
  end

`ifdef FP_ROUND_EN
  logic [FW:0] f_sum;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    m_d     = m_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    res_d   = res_q;
`ifdef FP_ROUND_EN
    f_sum   = '0;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = sm_sign | clamp;
          m_d     = clamp ? MAG_CLAMP : sm_mag[MW-1:0];
          exp_d   = EXP_MAX;
          state_d = NORM;
        end
      end

      NORM: begin
        if (norm_done(m_q, exp_q)) begin
          state_d = ROUND;
        end else begin
          m_d   = {m_q[MW-2:0], 1'b0};
          exp_d = exp_q - EW'(1);
        end
      end

      ROUND: begin
        res_d.s = sign_q;
        res_d.e = exp_q;
        res_d.f = m_q[MW-1 -: FW];
`ifdef FP_ROUND_EN
        f_sum = {1'b0, m_q[MW-1 -: FW]} + {{FW{1'b0}}, m_q[MW-1-FW]};
        if (f_sum[FW]) begin
          if (exp_q == EXP_MAX) begin
            res_d.e = EXP_MAX;
            res_d.f = F_SAT;
          end else begin
            res_d.e = exp_q + EW'(1);
            res_d.f = F_CARRY;
          end
        end else begin
          res_d.f = f_sum[FW-1:0];
        end
`endif
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_s     = res_q.s;
  assign out_e     = res_q.e;
  assign out_f     = res_q.f;

endmodule

// File: tb/tb_fp_conv_ctrl.sv
// Directed bench for fp_conv_ctrl: reset, conversion table, output stall, reset mid-conversion.
// Expected values for rounding cases depend on whether FP_ROUND_EN is defined.
module tb_fp_conv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_d;
  logic        out_valid;
  logic        out_ready;
  logic        out_s;
  logic [2:0]  out_e;
  logic [3:0]  out_f;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [11:0] d;
    logic        s;
    logic [2:0]  e;
    logic [3:0]  f;
    logic [7:0]  lat;
  } vec_t;

  always #5 clk = ~clk;

  fp_conv_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_d      (in_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_e     (out_e),
    .out_f     (out_f),
    .busy      (busy)
  );

  // Present a sample before a rising edge; returns in_ready as seen at acceptance.
  task automatic start_sample(input logic [11:0] d, output logic rdy);
    @(negedge clk);
    in_d     = d;
    in_valid = 1'b1;
    rdy      = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Cycles from acceptance (cycle 0) to the first out_valid; capped at 20.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_d      = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++;
    if ({out_s, out_e, out_f} !== 8'h00) begin
      n_fail++; $display("FAIL reset_outputs got=%h exp=00", {out_s, out_e, out_f});
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL idle_no_valid busy=%b in_ready=%b exp busy=0 in_ready=1", busy, in_ready);
    end
  endtask

  task automatic test_vectors();
    vec_t vecs[10];
    logic rdy;
    int   lat;
    vecs[0] = '{d: 12'h001, s: 1'b0, e: 3'd0, f: 4'b0001, lat: 8'd10};
    vecs[1] = '{d: 12'hFFF, s: 1'b1, e: 3'd0, f: 4'b0001, lat: 8'd10};
    vecs[2] = '{d: 12'd422, s: 1'b0, e: 3'd5, f: 4'b1101, lat: 8'd5};
    vecs[3] = '{d: 12'hE5A, s: 1'b1, e: 3'd5, f: 4'b1101, lat: 8'd5};
`ifdef FP_ROUND_EN
    vecs[4] = '{d: 12'd46,   s: 1'b0, e: 3'd2, f: 4'b1100, lat: 8'd8};
    vecs[5] = '{d: 12'd125,  s: 1'b0, e: 3'd4, f: 4'b1000, lat: 8'd7};
    vecs[6] = '{d: 12'd1023, s: 1'b0, e: 3'd7, f: 4'b1000, lat: 8'd4};
`else
    vecs[4] = '{d: 12'd46,   s: 1'b0, e: 3'd2, f: 4'b1011, lat: 8'd8};
    vecs[5] = '{d: 12'd125,  s: 1'b0, e: 3'd3, f: 4'b1111, lat: 8'd7};
    vecs[6] = '{d: 12'd1023, s: 1'b0, e: 3'd6, f: 4'b1111, lat: 8'd4};
`endif
    vecs[7] = '{d: 12'd2047, s: 1'b0, e: 3'd7, f: 4'b1111, lat: 8'd3};
    vecs[8] = '{d: 12'h800,  s: 1'b1, e: 3'd7, f: 4'b1111, lat: 8'd3};
    vecs[9] = '{d: 12'h000,  s: 1'b0, e: 3'd0, f: 4'b0000, lat: 8'd10};

    for (int i = 0; i < 10; i++) begin
      start_sample(vecs[i].d, rdy);
      n_checks++;
      if (rdy !== 1'b1) begin n_fail++; $display("FAIL accept_ready d=%h got=%b exp=1", vecs[i].d, rdy); end
      n_checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL busy_after_accept d=%h busy=%b in_ready=%b exp 1/0", vecs[i].d, busy, in_ready);
      end
      wait_valid(lat);
      n_checks++;
      if (lat !== int'(vecs[i].lat)) begin
        n_fail++; $display("FAIL latency d=%h got=%0d exp=%0d", vecs[i].d, lat, vecs[i].lat);
      end
      n_checks++;
      if ({out_s, out_e, out_f} !== {vecs[i].s, vecs[i].e, vecs[i].f}) begin
        n_fail++;
        $display("FAIL result d=%h got s=%b e=%0d f=%b exp s=%b e=%0d f=%b",
                 vecs[i].d, out_s, out_e, out_f, vecs[i].s, vecs[i].e, vecs[i].f);
      end
      release_out();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL handoff d=%h out_valid=%b in_ready=%b busy=%b exp 0/1/0",
                 vecs[i].d, out_valid, in_ready, busy);
      end
      n_checks++;
      if ({out_s, out_e, out_f} !== {vecs[i].s, vecs[i].e, vecs[i].f}) begin
        n_fail++; $display("FAIL hold_in_idle d=%h got=%h", vecs[i].d, {out_s, out_e, out_f});
      end
    end
  endtask

  task automatic test_stall();
    logic rdy;
    int   lat;
    start_sample(12'd422, rdy);
    wait_valid(lat);
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL stall_latency got=%0d exp=5", lat); end
    // A competing sample must be ignored while the result waits.
    in_d     = 12'h123;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_s, out_e, out_f} !== {1'b0, 3'd5, 4'b1101}) begin
        n_fail++;
        $display("FAIL stall_hold cycle=%0d out_valid=%b in_ready=%b out=%h exp 1/0/5d",
                 c, out_valid, in_ready, {out_s, out_e, out_f});
      end
    end
    in_valid = 1'b0;
    release_out();
    n_checks++;
    if (out_valid !== 1'b0 || {out_s, out_e, out_f} !== {1'b0, 3'd5, 4'b1101}) begin
      n_fail++; $display("FAIL stall_release out_valid=%b out=%h exp 0/5d", out_valid, {out_s, out_e, out_f});
    end
  endtask

  task automatic test_reset_mid();
    logic rdy;
    int   seen;
    start_sample(12'h001, rdy);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_ctrl in_ready=%b busy=%b out_valid=%b exp 1/0/0", in_ready, busy, out_valid);
    end
    n_checks++;
    if ({out_s, out_e, out_f} !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset_outputs got=%h exp=00", {out_s, out_e, out_f});
    end
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL mid_reset_no_result active_cycles=%0d exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
